// File: rtl/up_down_counter.sv
// Free-running bidirectional counter: steps by one every clock edge, direction
// chosen by up_down, wrapping silently modulo 2^WIDTH in both directions.
module up_down_counter #(
  parameter int          WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] out
);

  // RESET_VALUE may be wider than the counter; only the low WIDTH bits are kept.
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= RESET_COUNT;
    end else if (up_down) begin
      out <= out + ONE;
    end else begin
      out <= out - ONE;
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter: reset, counting both ways,
// wrap-around, reset mid-count and per-edge direction toggling.
module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic [7:0] out;

  int tests_run;
  int tests_failed;

  up_down_counter #(
    .WIDTH       (8),
    .RESET_VALUE (0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .up_down (up_down),
    .out     (out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Drives the inputs, lets one rising edge sample them, then settles past it.
  task automatic applyStimulus(input logic rst, input logic ud);
    reset   = rst;
    up_down = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    tests_run++;
    assert (out === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: out=%0d expected=%0d", tag, out, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    up_down      = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("reset_hold", 8'd0);
    end

    for (int i = 1; i <= 50; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("count_up", 8'(i));
    end
    checkOutput("count_up_end", 8'd50);

    for (int i = 49; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("count_down", 8'(i));
    end
    checkOutput("count_down_end", 8'd0);

    for (int i = 1; i <= 50; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("count_up_again", 8'(i));
    end
    checkOutput("count_up_again_end", 8'd50);

    for (int i = 49; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("back_to_zero", 8'd0);

    applyStimulus(1'b0, 1'b0);
    checkOutput("wrap_down", 8'd255);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap_up", 8'd0);

    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("full_cycle", 8'(i % 256));
    end
    checkOutput("full_cycle_end", 8'd0);

    for (int i = 1; i <= 37; i++) begin
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("at_37", 8'd37);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_mid_up", 8'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("resume_up", 8'd1);

    applyStimulus(1'b0, 1'b0);
    checkOutput("down_to_0", 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("down_to_255", 8'd255);
    applyStimulus(1'b0, 1'b0);
    checkOutput("down_to_254", 8'd254);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_mid_down", 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resume_down", 8'd255);

    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_before_toggle", 8'd0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("at_10", 8'd10);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      checkOutput("toggle", (i % 2 == 0) ? 8'd11 : 8'd10);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
